// File: rtl/dac_audio_out_if.sv
// Signal bundle between the DAC-word source and the audio output stage.
// The master drives the DAC word and controls; the slave returns PCM samples.
interface dac_audio_out_if;
  logic [13:0] DAC;
  logic        DACWRL;
  logic        MUTE;
  logic [1:0]  VOL;
  logic [15:0] AUDIO;
  logic        SAMPLE_STB;
  logic        ACTIVE;

  modport master (
    output DAC,
    output DACWRL,
    output MUTE,
    output VOL,
    input  AUDIO,
    input  SAMPLE_STB,
    input  ACTIVE
  );

  modport slave (
    input  DAC,
    input  DACWRL,
    input  MUTE,
    input  VOL,
    output AUDIO,
    output SAMPLE_STB,
    output ACTIVE
  );
endinterface

// File: rtl/dac_audio_out.sv
// Converts the latched offset-binary DAC word into a filtered, fixed-rate
// signed 16-bit PCM stream with mute, idle fade and volume shift.
module dac_audio_out #(
  parameter int unsigned CLK_HZ       = 25000000,
  parameter int unsigned OUT_HZ       = 48000,
  parameter int unsigned FILT_SHIFT   = 4,
  parameter int unsigned IDLE_SAMPLES = 4096
) (
  input  logic             MasterClock,
  input  logic             RESET,
  dac_audio_out_if.slave   bus
);

  localparam int unsigned YW = 16 + FILT_SHIFT;
  localparam int unsigned CW = $clog2(IDLE_SAMPLES + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q,    state_d;
  logic [31:0]          acc_q,      acc_d;
  logic signed [YW-1:0] y_q,        y_d;
  logic [CW-1:0]        idle_cnt_q, idle_cnt_d;
  logic                 wrl_prev_q, wrl_prev_d;
  logic [15:0]          audio_q,    audio_d;
  logic                 stb_q,      stb_d;
  logic                 active_q,   active_d;

  logic                 wr;
  logic                 stb;
  logic [32:0]          acc_sum;
  logic [32:0]          acc_wrap;
  logic signed [15:0]   x;
  logic signed [15:0]   tgt;
  logic signed [YW:0]   y_ext;
  logic signed [YW:0]   tgt_ext;
  logic signed [YW:0]   y_sum;
  logic signed [YW-1:0] y_new;
  logic signed [15:0]   o;
  logic signed [15:0]   o_att;

  always_comb begin
    wr         = wrl_prev_q & ~bus.DACWRL;
    wrl_prev_d = bus.DACWRL;

    // Fractional rate generator: the remainder is carried, so no long-term drift.
    acc_sum  = {1'b0, acc_q} + 33'(OUT_HZ);
    acc_wrap = acc_sum - 33'(CLK_HZ);
    stb      = (acc_sum >= 33'(CLK_HZ));
    acc_d    = stb ? acc_wrap[31:0] : acc_sum[31:0];

    x   = {~bus.DAC[13], bus.DAC[12:0], 2'b00};
    tgt = (bus.MUTE || (state_q == ST_IDLE && !wr)) ? 16'sd0 : x;

    y_ext   = {y_q[YW-1], y_q};
    tgt_ext = {{(YW + 1 - 16){tgt[15]}}, tgt};
    y_sum   = y_ext + tgt_ext - (y_ext >>> FILT_SHIFT);
    // Unreachable for legal FILT_SHIFT; clamps rather than wraps if it ever happened.
    if (y_sum[YW] != y_sum[YW-1]) begin
      y_new = {y_sum[YW], {(YW - 1){~y_sum[YW]}}};
    end else begin
      y_new = y_sum[YW-1:0];
    end

    o     = y_new[YW-1:FILT_SHIFT];
    o_att = o >>> bus.VOL;

    y_d     = stb ? y_new : y_q;
    audio_d = stb ? o_att : audio_q;
    stb_d   = stb;

    // A write outranks a coincident strobe for the idle counter.
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    if (wr) begin
      state_d    = ST_RUN;
      idle_cnt_d = '0;
    end else if (stb && state_q == ST_RUN) begin
      idle_cnt_d = idle_cnt_q + CW'(1);
      if (idle_cnt_d == CW'(IDLE_SAMPLES)) begin
        state_d = ST_IDLE;
      end
    end
    active_d = (state_d == ST_RUN);
  end

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      y_q        <= '0;
      idle_cnt_q <= '0;
      wrl_prev_q <= 1'b1;
      audio_q    <= '0;
      stb_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      y_q        <= y_d;
      idle_cnt_q <= idle_cnt_d;
      wrl_prev_q <= wrl_prev_d;
      audio_q    <= audio_d;
      stb_q      <= stb_d;
      active_q   <= active_d;
    end
  end

  assign bus.AUDIO      = audio_q;
  assign bus.SAMPLE_STB = stb_q;
  assign bus.ACTIVE     = active_q;

endmodule
